// File: rtl/bidir_port_ctrl_if.sv
// Core-side handshake bundle for bidir_port_ctrl; the pad bus itself stays a plain inout.
// master = core logic, slave = the port controller.
interface bidir_port_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             dir_req;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             oe_active;
   logic             busy;

   modport master (
      output dir_req, tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, oe_active, busy
   );

   modport slave (
      input  dir_req, tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, oe_active, busy
   );
endinterface

// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad controller: registered output path, synchronised input path and
// a turnaround FSM that keeps the bus released for TURNAROUND cycles on every direction change.
module bidir_port_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TURNAROUND  = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   bidir_port_ctrl_if.slave port,
   inout  logic [WIDTH-1:0] bidir
);
   localparam int unsigned CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam int unsigned FW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] TURN_LOAD = CW'(TURNAROUND - 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_STAGES);

   typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;

   state_t           state;
   logic [CW-1:0]    turn_cnt;
   logic [FW-1:0]    fill;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic             oe_q;
   logic             accept;

   assign port.tx_ready  = (state == TX) && port.dir_req;
   assign accept         = port.tx_valid && port.tx_ready;
   assign port.rx_data   = sync_q[SYNC_STAGES-1];
   assign port.rx_valid  = (state == RX) && (fill == FILL_FULL);
   assign port.busy      = (state == TURN_TX) || (state == TURN_RX);
   assign port.oe_active = oe_q;
   assign bidir          = oe_q ? out_reg : 'z;

   // Turnaround counter counts down from TURNAROUND-1 so the exit edge lands on zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RX;
         turn_cnt <= '0;
         fill     <= '0;
         out_reg  <= '0;
         oe_q     <= 1'b0;
      end else begin
         if (accept) out_reg <= port.tx_data;
         unique case (state)
            RX: begin
               if (port.dir_req) begin
                  state    <= TURN_TX;
                  turn_cnt <= TURN_LOAD;
               end else if (fill != FILL_FULL) begin
                  fill <= fill + FW'(1);
               end
            end
            TURN_TX: begin
               if (turn_cnt == '0) begin
                  state <= TX;
                  oe_q  <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt - CW'(1);
               end
            end
            TX: begin
               if (!port.dir_req) begin
                  state    <= TURN_RX;
                  turn_cnt <= TURN_LOAD;
                  oe_q     <= 1'b0;
               end
            end
            TURN_RX: begin
               if (turn_cnt == '0) begin
                  state <= RX;
                  fill  <= '0;
               end else begin
                  turn_cnt <= turn_cnt - CW'(1);
               end
            end
            default: state <= RX;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bidir;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Randomised self-checking bench for bidir_port_ctrl against a timestamp-based model
// of direction changes, word acceptance and the input sampling history.
module tb_bidir_port_ctrl;
   localparam int unsigned W = 8;
   localparam int unsigned T = 2;
   localparam int unsigned S = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bidir_port_ctrl_if #(.WIDTH(W)) port ();

   logic         ext_en;
   logic [W-1:0] ext_val;
   wire  [W-1:0] bidir;
   assign bidir = ext_en ? ext_val : 'z;

   bidir_port_ctrl #(.WIDTH(W), .TURNAROUND(T), .SYNC_STAGES(S)) dut (
      .clk   (clk),
      .rst   (rst),
      .port  (port),
      .bidir (bidir)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 'side' is the settled direction (1 = driving); a requested change
   // starts a turnaround that completes at edge 'switch_at'.
   int           cyc       = 0;
   int           switch_at = 0;
   int           rx_start  = 0;
   bit           side      = 1'b0;
   bit           target    = 1'b0;
   bit           in_turn   = 1'b0;
   bit           armed     = 1'b0;
   logic [W-1:0] out_word  = '0;
   logic [W-1:0] hist[$];

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_oe();
      return side && !in_turn;
   endfunction

   task automatic model_step(input bit r, input bit d, input bit acc,
                             input logic [W-1:0] td, input logic [W-1:0] bus);
      cyc++;
      if (r) begin
         side     = 1'b0;
         in_turn  = 1'b0;
         rx_start = cyc;
         out_word = '0;
         hist.delete();
         for (int i = 0; i < S; i++) hist.push_front('0);
      end else begin
         if (acc) out_word = td;
         hist.push_front(bus);
         void'(hist.pop_back());
         if (in_turn) begin
            if (cyc == switch_at) begin
               in_turn = 1'b0;
               side    = target;
               if (!side) rx_start = cyc;
            end
         end else if (d != side) begin
            in_turn   = 1'b1;
            target    = d;
            switch_at = cyc + T;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit d, input bit v,
                        input logic [W-1:0] td, input logic [W-1:0] xv);
      logic [W-1:0] bus_now;
      bit           rdy;
      rst           = r;
      port.dir_req  = d;
      port.tx_valid = v;
      port.tx_data  = td;
      ext_en        = !m_oe();
      ext_val       = xv;
      #1;
      rdy     = m_oe() && d;
      bus_now = m_oe() ? out_word : xv;
      if (armed) begin
         check_eq("tx_ready", W'(port.tx_ready), W'(rdy));
         check_eq("bidir", bidir, bus_now);
      end
      @(posedge clk);
      model_step(r, d, v && rdy, td, bus_now);
      #1;
      armed = 1'b1;
      check_eq("oe_active", W'(port.oe_active), W'(m_oe()));
      check_eq("busy", W'(port.busy), W'(in_turn));
      check_eq("rx_valid", W'(port.rx_valid), W'(!side && !in_turn && (cyc - rx_start >= S)));
      check_eq("rx_data", port.rx_data, hist[S-1]);
   endtask

   initial begin
      bit d;
      // Reset, then listen to an external 8'hA5
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'hA5);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'hA5);
      // Turn to TX; first driven word is the reset value
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h5A);
      // Accept one word, then hold it
      cycle(1'b0, 1'b1, 1'b1, 8'h3C, 8'h00);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
      // Drop dir_req with a word offered: must not be loaded
      repeat (6) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 8'h96);
      // Reverse the request mid TURN_TX
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h11);
      repeat (7) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h22);
      // Reset while driving, then re-enter TX
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h33);
      cycle(1'b0, 1'b1, 1'b1, 8'h3C, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h44);
      repeat (5) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h55);
      // Randomised traffic
      d = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) d = ~d;
         cycle(($urandom_range(0, 149) == 0), d, 1'($urandom),
               W'($urandom), W'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bidir_port_ctrl.md
# bidir_port_ctrl

Parametrised bidirectional pad controller with a registered output path, a synchronised input path and a contention-free direction-turnaround state machine. It adds what a plain output-enable port lacks: configurable width, guaranteed high-impedance dead cycles on every direction change, a multi-stage input synchroniser, and ready/valid handshakes on both sides. It sits between core logic and a shared external bus pin group, one instance per bus.

## Interface
- WIDTH, 8, bus and data width in bits (>= 1)
- TURNAROUND, 2, high-impedance cycles inserted on every direction change (>= 1)
- SYNC_STAGES, 2, input synchroniser depth in flops (>= 2)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- dir_req  input  1  1 = request to drive the bus, 0 = request to listen
- tx_data  input  WIDTH  word to drive
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  word accepted on tx_valid & tx_ready
- rx_data  output  WIDTH  synchronised bus value
- rx_valid  output  1  rx_data reflects bus samples taken while listening
- oe_active  output  1  registered copy of bus output enable
- busy  output  1  high during turnaround states
- bidir  inout  WIDTH  bus; driven with output register when oe_active, else all-z

## Operation
- States: RX (listen, bus z), TURN_TX (z, counting), TX (driving), TURN_RX (z, counting).
- Reset: state RX, output register 0, synchroniser flops 0, turnaround counter 0, fill counter 0; outputs tx_ready=0, rx_valid=0, oe_active=0, busy=0, rx_data=0, bidir=z.
- RX: dir_req=1 -> TURN_TX, counter loaded. dir_req=0 -> stay.
- TURN_TX / TURN_RX: stay exactly TURNAROUND cycles, then go to TX / RX respectively. dir_req ignored here; a reversed request takes effect from the destination state.
- TX: dir_req=0 -> TURN_RX. Otherwise stay.
- tx_ready = (state==TX) & dir_req, combinational. On tx_valid & tx_ready the output register loads tx_data; bidir shows it from the next cycle.
- Output register holds its value across direction changes; entering TX drives the last accepted word (0 after reset).
- Input path: stage 0 samples bidir every edge; stages shift every edge; rx_data = last stage.
- Fill counter clears on entering RX, increments per RX cycle, saturates at SYNC_STAGES. rx_valid = (state==RX) & (fill == SYNC_STAGES).
- busy = state is TURN_TX or TURN_RX.

## Timing
- oe_active is a registered state decode: rises on the same edge state becomes TX, falls on the same edge state leaves TX. The bus is therefore never driven during RX, TURN_TX or TURN_RX.
- Direction change latency: dir_req change sampled at edge E -> turnaround states for edges E..E+TURNAROUND-1 -> new state at edge E+TURNAROUND.
- rx_valid: state enters RX at edge E; rx_valid high after edge E+SYNC_STAGES; low after the edge that leaves RX.
- rx_data latency: bus value stable before edge N appears on rx_data after edge N+SYNC_STAGES-1.
- tx latency: accepted at edge N, on bidir after edge N, stable for edge N+1 sampling.
- Accept on the last TX cycle is impossible: tx_ready already 0 when dir_req=0.
- rst at any edge: all registers return to reset values that edge; bus released to z immediately after that edge, even mid-TX or mid-turnaround.

## Test plan
- Reset, dir_req=0, external drive 8'hA5 -> rx_valid=0 until SYNC_STAGES (2) cycles in RX, then rx_valid=1, rx_data=8'hA5; oe_active=0, bidir undriven by DUT.
- dir_req 0->1 at edge E -> busy=1 edges E, E+1; oe_active=1 and tx_ready=1 after edge E+2; bidir=8'h00.
- In TX, tx_valid=1 tx_data=8'h3C for one cycle -> accepted, bidir=8'h3C next cycle and held with tx_valid=0.
- dir_req 1->0 in TX with tx_valid=1 -> tx_ready=0 that cycle, oe_active=0 after edge, 2 busy cycles, RX re-entered, rx_valid after 2 more cycles; word not loaded.
- dir_req toggled 1->0 during TURN_TX -> TX still reached after 2 cycles, then immediate TURN_RX; bus driven for exactly 1 cycle.
- rst asserted mid-TX with bidir=8'h3C -> after that edge oe_active=0, bidir=z, rx_valid=0; next TX entry drives 8'h00.
